// File: rtl/rv_pkg.sv
// Shared definitions for the RV32 subset decode/execute slice:
// datapath width, opcode constants and ALU operation encoding.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_SLL = 3'b010,
        ALU_SLT = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SRL = 3'b101,
        ALU_OR  = 3'b110,
        ALU_AND = 3'b111
    } alusel_t;

    // Maps funct3 and the SUB bit to an ALU select; funct3 010/011 map to SLT, 101 to SRL.
    function automatic alusel_t funct3_to_alusel(input logic [2:0] funct3, input logic sub);
        alusel_t sel;
        case (funct3)
            3'b000:  sel = sub ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLT;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = ALU_SRL;
            3'b110:  sel = ALU_OR;
            3'b111:  sel = ALU_AND;
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Purely combinational ALU for the EX stage.
module exec_alu
    import rv_pkg::*;
(
    input  logic [XLEN-1:0] i_operand1,
    input  logic [XLEN-1:0] i_operand2,
    input  alusel_t         i_alusel,
    output logic [XLEN-1:0] o_result
);

    // Operation select; only operand2[4:0] is meaningful as a shift amount.
    always_comb begin
        o_result = 32'd0;
        case (i_alusel)
            ALU_ADD: o_result = i_operand1 + i_operand2;
            ALU_SUB: o_result = i_operand1 - i_operand2;
            ALU_SLL: o_result = i_operand1 << i_operand2[4:0];
            ALU_SLT: o_result = {31'd0, ($signed(i_operand1) < $signed(i_operand2))};
            ALU_XOR: o_result = i_operand1 ^ i_operand2;
            ALU_SRL: o_result = i_operand1 >> i_operand2[4:0];
            ALU_OR:  o_result = i_operand1 | i_operand2;
            ALU_AND: o_result = i_operand1 & i_operand2;
            default: o_result = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_execute_unit.sv
// ID-stage decode/control/immediate generation, ID/EX pipeline register
// and the EX-stage ALU for the RV32 subset pipeline.
module decode_execute_unit
    import rv_pkg::*;
#(
    parameter int XLEN_P = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [XLEN_P-1:0] id_inst,
    input  logic [XLEN_P-1:0] id_pc,
    input  logic [XLEN_P-1:0] id_rs1_data,
    input  logic [XLEN_P-1:0] id_rs2_data,
    output logic [4:0]        id_rs1_addr,
    output logic [4:0]        id_rs2_addr,
    output logic [XLEN_P-1:0] ex_pc,
    output logic [6:0]        ex_opcode,
    output logic [4:0]        ex_rd,
    output logic              ex_reg_write,
    output logic              ex_load,
    output logic              ex_store,
    output logic              ex_jump,
    output logic              ex_branch_taken,
    output logic [XLEN_P-1:0] ex_result,
    output logic [XLEN_P-1:0] ex_store_data,
    output logic [XLEN_P-1:0] ex_link
);

    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j;
    logic [31:0] w_op1, w_op2, w_alu_result;
    alusel_t     w_alusel;
    logic        w_writes_rd, w_load, w_store, w_jump;

    logic [31:0] r_pc, r_op1, r_op2, r_rs1_data, r_rs2_data;
    logic [6:0]  r_opcode;
    logic [4:0]  r_rd;
    alusel_t     r_alusel;
    logic        r_reg_write, r_load, r_store, r_jump;

    assign w_opcode    = id_inst[6:0];
    assign w_rd        = id_inst[11:7];
    assign w_funct3    = id_inst[14:12];
    assign id_rs1_addr = id_inst[19:15];
    assign id_rs2_addr = id_inst[24:20];

    assign w_imm_i = {{20{id_inst[31]}}, id_inst[31:20]};
    assign w_imm_s = {{20{id_inst[31]}}, id_inst[31:25], id_inst[11:7]};
    assign w_imm_b = {{20{id_inst[31]}}, id_inst[7], id_inst[30:25], id_inst[11:8], 1'b0};
    assign w_imm_j = {{12{id_inst[31]}}, id_inst[19:12], id_inst[20], id_inst[30:21], 1'b0};

    // Decode: controls, operand muxing and ALU select; unknown opcodes become a bubble.
    always_comb begin
        w_op1       = 32'd0;
        w_op2       = 32'd0;
        w_alusel    = ALU_ADD;
        w_writes_rd = 1'b0;
        w_load      = 1'b0;
        w_store     = 1'b0;
        w_jump      = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_op1       = id_rs1_data;
                w_op2       = id_rs2_data;
                w_alusel    = funct3_to_alusel(w_funct3, id_inst[30]);
                w_writes_rd = 1'b1;
            end
            OP_I: begin
                w_op1       = id_rs1_data;
                w_op2       = w_imm_i;
                w_alusel    = funct3_to_alusel(w_funct3, 1'b0);
                w_writes_rd = 1'b1;
            end
            OP_LW: begin
                w_op1       = id_rs1_data;
                w_op2       = w_imm_i;
                w_writes_rd = 1'b1;
                w_load      = 1'b1;
            end
            OP_SW: begin
                w_op1   = id_rs1_data;
                w_op2   = w_imm_s;
                w_store = 1'b1;
            end
            OP_BEQ: begin
                w_op1 = id_pc;
                w_op2 = w_imm_b;
            end
            OP_JAL: begin
                w_op1       = id_pc;
                w_op2       = w_imm_j;
                w_writes_rd = 1'b1;
                w_jump      = 1'b1;
            end
            default: begin
                w_op1 = 32'd0;
                w_op2 = 32'd0;
            end
        endcase
    end

    // ID/EX register: reset inserts a bubble, stall holds the current contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= 32'd0;
            r_opcode    <= 7'd0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_load      <= 1'b0;
            r_store     <= 1'b0;
            r_jump      <= 1'b0;
            r_op1       <= 32'd0;
            r_op2       <= 32'd0;
            r_alusel    <= ALU_ADD;
            r_rs1_data  <= 32'd0;
            r_rs2_data  <= 32'd0;
        end else if (!stall) begin
            r_pc        <= id_pc;
            r_opcode    <= w_opcode;
            r_rd        <= w_rd;
            r_reg_write <= w_writes_rd && (w_rd != 5'd0);
            r_load      <= w_load;
            r_store     <= w_store;
            r_jump      <= w_jump;
            r_op1       <= w_op1;
            r_op2       <= w_op2;
            r_alusel    <= w_alusel;
            r_rs1_data  <= id_rs1_data;
            r_rs2_data  <= id_rs2_data;
        end
    end

    exec_alu u_exec_alu (
        .i_operand1 (r_op1),
        .i_operand2 (r_op2),
        .i_alusel   (r_alusel),
        .o_result   (w_alu_result)
    );

    assign ex_pc           = r_pc;
    assign ex_opcode       = r_opcode;
    assign ex_rd           = r_rd;
    assign ex_reg_write    = r_reg_write;
    assign ex_load         = r_load;
    assign ex_store        = r_store;
    assign ex_jump         = r_jump;
    assign ex_branch_taken = (r_opcode == OP_BEQ) && (r_rs1_data == r_rs2_data);
    assign ex_result       = w_alu_result;
    assign ex_store_data   = r_rs2_data;
    assign ex_link         = r_pc + 32'd4;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Randomized self-checking bench for decode_execute_unit against a behavioural model.
module tb_decode_execute_unit;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic [31:0] id_inst, id_pc, id_rs1_data, id_rs2_data;
    logic [4:0]  id_rs1_addr, id_rs2_addr;
    logic [31:0] ex_pc, ex_result, ex_store_data, ex_link;
    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_load, ex_store, ex_jump, ex_branch_taken;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic        rw, ld, st, jp, br;
        logic [31:0] res, sd, link;
    } exp_t;

    exp_t exp_s;

    decode_execute_unit dut (
        .clk(clk), .rst(rst), .stall(stall),
        .id_inst(id_inst), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_load(ex_load), .ex_store(ex_store),
        .ex_jump(ex_jump), .ex_branch_taken(ex_branch_taken),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_link(ex_link)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    // Result of one funct3-selected operation on two 32-bit values.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic sub,
                                           input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    return sub ? a - b : a + b;
            3'd1:    return a << (b % 32);
            3'd2,
            3'd3:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return a >> (b % 32);
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic exp_t predict(input logic [31:0] inst, input logic [31:0] pc,
                                     input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        logic signed [11:0] ii, ss;
        logic signed [12:0] bb;
        logic signed [20:0] jj;
        int imm_i, imm_s, imm_b, imm_j;
        ii = inst[31:20];
        ss = {inst[31:25], inst[11:7]};
        bb = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        jj = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        imm_i = ii; imm_s = ss; imm_b = bb; imm_j = jj;
        e.pc = pc; e.opc = inst[6:0]; e.rd = inst[11:7];
        e.sd = d2; e.link = pc + 32'd4;
        e.rw = 1'b0; e.ld = 1'b0; e.st = 1'b0; e.jp = 1'b0; e.res = 32'd0;
        case (inst[6:0])
            7'b0110011: begin e.res = ref_op(inst[14:12], inst[30], d1, d2); e.rw = 1'b1; end
            7'b0010011: begin e.res = ref_op(inst[14:12], 1'b0, d1, imm_i); e.rw = 1'b1; end
            7'b0000011: begin e.res = d1 + imm_i; e.rw = 1'b1; e.ld = 1'b1; end
            7'b0100011: begin e.res = d1 + imm_s; e.st = 1'b1; end
            7'b1100011: e.res = pc + imm_b;
            7'b1101111: begin e.res = pc + imm_j; e.rw = 1'b1; e.jp = 1'b1; end
            default:    e.res = 32'd0;
        endcase
        if (inst[11:7] == 5'd0) e.rw = 1'b0;
        e.br = (inst[6:0] == 7'b1100011) && (d1 == d2);
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.pc = 32'd0; e.opc = 7'd0; e.rd = 5'd0;
        e.rw = 1'b0; e.ld = 1'b0; e.st = 1'b0; e.jp = 1'b0; e.br = 1'b0;
        e.res = 32'd0; e.sd = 32'd0; e.link = 32'd4;
        return e;
    endfunction

    task automatic check_all(input string tag);
        check_val({tag, ".rs1a"}, {27'd0, id_rs1_addr}, {27'd0, id_inst[19:15]});
        check_val({tag, ".rs2a"}, {27'd0, id_rs2_addr}, {27'd0, id_inst[24:20]});
        check_val({tag, ".pc"},   ex_pc, exp_s.pc);
        check_val({tag, ".opc"},  {25'd0, ex_opcode}, {25'd0, exp_s.opc});
        check_val({tag, ".rd"},   {27'd0, ex_rd}, {27'd0, exp_s.rd});
        check_val({tag, ".flags"},
                  {27'd0, ex_reg_write, ex_load, ex_store, ex_jump, ex_branch_taken},
                  {27'd0, exp_s.rw, exp_s.ld, exp_s.st, exp_s.jp, exp_s.br});
        check_val({tag, ".res"},  ex_result, exp_s.res);
        check_val({tag, ".sd"},   ex_store_data, exp_s.sd);
        check_val({tag, ".link"}, ex_link, exp_s.link);
    endtask

    // Drive one ID-stage instruction, clock once, update the model.
    task automatic step(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2, input logic stl);
        id_inst = inst; id_pc = pc; id_rs1_data = d1; id_rs2_data = d2; stall = stl;
        @(posedge clk);
        #1;
        if (!stl) exp_s = predict(inst, pc, d1, d2);
    endtask

    logic [6:0] opc_tab [7];

    initial begin
        opc_tab = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                    7'b1100011, 7'b1101111, 7'b0000000};
        rst = 1'b1; stall = 1'b0;
        id_inst = 32'd0; id_pc = 32'd0; id_rs1_data = 32'd0; id_rs2_data = 32'd0;
        exp_s = bubble();
        #2;
        check_all("reset0");
        #10;
        rst = 1'b0;

        step(32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0);
        check_val("add.rs1a", {27'd0, id_rs1_addr}, 32'd1);
        check_val("add.rs2a", {27'd0, id_rs2_addr}, 32'd2);
        check_val("add.res", ex_result, 32'd12);
        check_val("add.rd", {27'd0, ex_rd}, 32'd3);
        check_val("add.rw", {31'd0, ex_reg_write}, 32'd1);

        rst = 1'b1;
        #1;
        exp_s = bubble();
        check_val("rst.res", ex_result, 32'd0);
        check_val("rst.rw", {31'd0, ex_reg_write}, 32'd0);
        check_val("rst.rd", {27'd0, ex_rd}, 32'd0);
        check_val("rst.link", ex_link, 32'd4);
        check_all("rst");
        @(negedge clk);
        rst = 1'b0;

        step(32'h402081B3, 32'h4, 32'd5, 32'd7, 1'b0);
        check_val("sub.res", ex_result, 32'hFFFFFFFE);
        step(32'hFFF08293, 32'h8, 32'd10, 32'd0, 1'b0);
        check_val("addi.res", ex_result, 32'd9);
        check_val("addi.rd", {27'd0, ex_rd}, 32'd5);
        step(32'h00208463, 32'h100, 32'd4, 32'd4, 1'b0);
        check_val("beq.res", ex_result, 32'h108);
        check_val("beq.taken", {31'd0, ex_branch_taken}, 32'd1);
        check_val("beq.rw", {31'd0, ex_reg_write}, 32'd0);
        step(32'h00208463, 32'h100, 32'd4, 32'd5, 1'b0);
        check_val("beq.nt", {31'd0, ex_branch_taken}, 32'd0);
        step(32'h010000EF, 32'h200, 32'd0, 32'd0, 1'b0);
        check_val("jal.res", ex_result, 32'h210);
        check_val("jal.link", ex_link, 32'h204);
        check_val("jal.jump", {31'd0, ex_jump}, 32'd1);
        check_val("jal.rw", {31'd0, ex_reg_write}, 32'd1);
        check_val("jal.rd", {27'd0, ex_rd}, 32'd1);

        step(32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(32'h402081B3, 32'h4, 32'd5, 32'd7, 1'b1);
            check_val("stall.res", ex_result, 32'd12);
        end
        step(32'h402081B3, 32'h4, 32'd5, 32'd7, 1'b0);
        check_val("unstall.res", ex_result, 32'hFFFFFFFE);
        check_all("directed");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] inst, d1, d2;
            inst = $urandom;
            inst[6:0] = opc_tab[$urandom_range(6, 0)];
            d1 = ($urandom_range(3, 0) == 0) ? ($urandom_range(15, 0) - 8) : $urandom;
            d2 = ($urandom_range(3, 0) == 0) ? d1 : $urandom;
            step(inst, $urandom & 32'hFFFF_FFFC, d1, d2, ($urandom_range(4, 0) == 0));
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
